// File: rtl/simon_decrypt_controller_pkg.sv
// Shared constants and types for the SIMON32/64 decrypt controller slice.
package simon_pkg;
  localparam int ROUNDS  = 32;
  localparam int COUNT_W = $clog2(ROUNDS);
  localparam int KEY_W   = 64;
  localparam int BLOCK_W = 32;

  typedef logic [KEY_W-1:0]   simon_key_t;
  typedef logic [BLOCK_W-1:0] simon_block_t;
  typedef logic [COUNT_W-1:0] simon_count_t;

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} dec_ctrl_state_t;

  localparam simon_count_t LAST_ROUND = simon_count_t'(ROUNDS - 1);
endpackage

// File: rtl/simon_decrypt_controller_if.sv
// Job-in / plaintext-out handshake bundle for the SIMON decrypt controller.
// A transfer happens on a rising edge where valid && ready; the source keeps
// valid and data stable until that edge, and ready never depends on valid.
interface simon_decrypt_controller_if;
  import simon_pkg::*;

  logic         in_valid;
  logic         in_ready;
  simon_key_t   key_in;
  simon_block_t ct_in;
  logic         out_valid;
  logic         out_ready;
  simon_block_t pt_out;

  modport slave (
    input  in_valid, key_in, ct_in, out_ready,
    output in_ready, out_valid, pt_out
  );

  modport master (
    output in_valid, key_in, ct_in, out_ready,
    input  in_ready, out_valid, pt_out
  );
endinterface

// File: rtl/simon_decrypt_controller_job_buf.sv
// One-entry holding register {key, ct, full} for a prefetched decrypt job.
module simon_dec_job_buf
  import simon_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  simon_key_t   push_key,
  input  simon_block_t push_ct,
  output logic         full,
  output simon_key_t   key,
  output simon_block_t ct
);
  // push is only raised while empty and pop only while full, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      key  <= '0;
      ct   <= '0;
    end else begin
      if (push) begin
        key  <= push_key;
        ct   <= push_ct;
        full <= 1'b1;
      end else if (pop) begin
        full <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/simon_decrypt_controller.sv
// Sequences one SIMON32/64 decrypt job at a time through the cipher core.
// SIMON_DEC_PREFETCH_EN adds a one-entry job buffer so the next job can wait.
module simon_decrypt_controller
  import simon_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  simon_decrypt_controller_if.slave   bus,
  output logic                        core_load,
  output simon_key_t                  core_key,
  output simon_block_t                core_text,
  output simon_count_t                core_count,
  input  simon_block_t                core_result,
  output logic                        busy,
  output dec_ctrl_state_t             state_dbg
);
  dec_ctrl_state_t state_q, state_d;
  simon_block_t    pt_q;
  simon_key_t      buf_key;
  simon_block_t    buf_ct;
  logic            last_round;
  logic            load_direct;
  logic            load_buf;

`ifdef SIMON_DEC_PREFETCH_EN
  logic buf_full;
  logic buf_push;
  logic accept;

  assign bus.in_ready = !buf_full;
  assign accept       = bus.in_valid && !buf_full;
  assign load_direct  = accept && (state_q == IDLE);
  assign buf_push     = accept && (state_q != IDLE);
  // A buffered job starts on the DONE handshake, or from IDLE if it landed
  // in the buffer on that same handshake cycle.
  assign load_buf     = buf_full && ((state_q == IDLE) ||
                                     ((state_q == DONE) && bus.out_ready));

  simon_dec_job_buf u_job_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .pop      (load_buf),
    .push_key (bus.key_in),
    .push_ct  (bus.ct_in),
    .full     (buf_full),
    .key      (buf_key),
    .ct       (buf_ct)
  );
`else
  assign bus.in_ready = (state_q == IDLE);
  assign load_direct  = bus.in_valid && (state_q == IDLE);
  assign load_buf     = 1'b0;
  assign buf_key      = '0;
  assign buf_ct       = '0;
`endif

  assign last_round    = (state_q == ROUND) && (core_count == LAST_ROUND);
  assign core_load     = (state_q == LOAD);
  assign busy          = (state_q == LOAD) || (state_q == ROUND);
  assign bus.out_valid = (state_q == DONE);
  assign bus.pt_out    = pt_q;
  assign state_dbg     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_direct || load_buf) state_d = LOAD;
      LOAD:    state_d = ROUND;
      ROUND:   if (last_round) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = load_buf ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // core_key/core_text change only when a job starts, so the core may sample them anytime
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_key   <= '0;
      core_text  <= '0;
      core_count <= '0;
      pt_q       <= '0;
    end else begin
      if (load_direct) begin
        core_key  <= bus.key_in;
        core_text <= bus.ct_in;
      end else if (load_buf) begin
        core_key  <= buf_key;
        core_text <= buf_ct;
      end
      if ((state_q == ROUND) && !last_round) core_count <= core_count + simon_count_t'(1);
      else                                   core_count <= '0;
      if (last_round) pt_q <= core_result;
    end
  end
endmodule

// File: tb/tb_simon_decrypt_controller.sv
// Bench for simon_decrypt_controller with a behavioural SIMON32/64 core attached;
// build with SIMON_DEC_PREFETCH_EN defined to exercise the prefetch buffer.
module tb_simon_decrypt_controller;
  import simon_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            core_load;
  logic            busy;
  simon_key_t      core_key;
  simon_block_t    core_text;
  simon_block_t    core_result;
  simon_count_t    core_count;
  dec_ctrl_state_t state_dbg;

  simon_decrypt_controller_if bus();

  simon_decrypt_controller dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .core_load   (core_load),
    .core_key    (core_key),
    .core_text   (core_text),
    .core_count  (core_count),
    .core_result (core_result),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SIMON32/64 reference ----------------
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam simon_key_t   KAT_KEY = 64'h1918111009080100;
  localparam simon_block_t KAT_CT  = 32'hc69be9bb;
  localparam simon_block_t KAT_PT  = 32'h65656877;
`ifdef SIMON_DEC_PREFETCH_EN
  localparam logic EXP_RDY_DONE = 1'b1;
`else
  localparam logic EXP_RDY_DONE = 1'b0;
`endif

  function automatic logic [15:0] rol16(logic [15:0] v, int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] ror16(logic [15:0] v, int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [15:0] f16(logic [15:0] x);
    return (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2);
  endfunction

  function automatic logic [15:0] round_key(simon_key_t key, int idx);
    logic [15:0] k [0:31];
    logic [15:0] tmp;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp  = ror16(k[i-1], 3) ^ k[i-3];
      tmp  = tmp ^ ror16(tmp, 1);
      k[i] = ~k[i-4] ^ tmp ^ {15'd0, Z0[61 - ((i - 4) % 62)]} ^ 16'd3;
    end
    return k[idx];
  endfunction

  function automatic simon_block_t encrypt(simon_key_t key, simon_block_t pt);
    logic [15:0] x, y, t;
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ f16(x) ^ round_key(key, i);
      y = t;
    end
    return {x, y};
  endfunction

  // Core: state loaded on core_load, one inverse round per cycle, keys consumed in reverse.
  simon_block_t core_state;
  always @(posedge clk) begin
    if (core_load) core_state <= core_text;
    else           core_state <= core_result;
  end
  always_comb begin
    core_result = {core_state[15:0],
                   core_state[31:16] ^ f16(core_state[15:0]) ^
                   round_key(core_key, ROUNDS - 1 - int'(core_count))};
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [BLOCK_W-1:0] exp_q [$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the acceptance edge E0.
  task automatic accept_job(simon_key_t key, simon_block_t ct);
    int n;
    n = 0;
    bus.key_in   = key;
    bus.ct_in    = ct;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("accept_timeout", n < 100, 1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(output int t);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("out_valid_timeout", n < 100, 1);
    t = cyc;
  endtask

  // Checks the LOAD cycle, the 32-round count sweep and the capture edge E0+33.
  task automatic check_rounds(simon_key_t key, simon_block_t ct);
    logic [BLOCK_W-1:0] exp_pt;
    chk("load_strobe", core_load, 1);
    chk("load_busy", busy, 1);
    chk("load_count", core_count, 0);
    chk("core_key", core_key, key);
    chk("core_text", core_text, ct);
    for (int j = 0; j < ROUNDS; j++) begin
      step();
      chk("round_count", core_count, j);
      chk("round_load_low", core_load, 0);
      chk("round_busy", busy, 1);
      chk("round_out_valid", bus.out_valid, 0);
      chk("round_key_stable", core_key, key);
    end
    step();
    exp_pt = exp_q.pop_front();
    chk("done_out_valid", bus.out_valid, 1);
    chk("done_pt", bus.pt_out, exp_pt);
    chk("done_busy", busy, 0);
    chk("done_count", core_count, 0);
  endtask

  task automatic drain(int hold);
    simon_block_t held;
    held = bus.pt_out;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_pt_stable", bus.pt_out, held);
      chk("bp_in_ready", bus.in_ready, EXP_RDY_DONE);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("drain_out_valid", bus.out_valid, 0);
    chk("drain_idle", state_dbg, IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    simon_key_t   key, key2;
    simon_block_t pt, pt2, ct, ct2;
    int           ta, tb;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.key_in    = '0;
    bus.ct_in     = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state_dbg, IDLE);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_core_load", core_load, 0);
    chk("rst_count", core_count, 0);
    chk("rst_pt", bus.pt_out, 0);
    chk("rst_key", core_key, 0);
    chk("rst_text", core_text, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", bus.in_ready, 1);

    // Idle hygiene: out_ready toggling with no job changes nothing.
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = (i % 2 == 0);
      step();
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_state", state_dbg, IDLE);
    end
    bus.out_ready = 1'b0;

    // Known answer with 10 cycles of backpressure.
    exp_q.push_back(KAT_PT);
    accept_job(KAT_KEY, KAT_CT);
    check_rounds(KAT_KEY, KAT_CT);
    drain(10);

    // Random jobs.
    for (int r = 0; r < 6; r++) begin
      key = {$urandom, $urandom};
      pt  = $urandom;
      ct  = encrypt(key, pt);
      exp_q.push_back(pt);
      accept_job(key, ct);
      check_rounds(key, ct);
      drain($urandom_range(0, 3));
    end

`ifndef SIMON_DEC_PREFETCH_EN
    // Offer a second job while busy and in DONE: only the output handshake completes.
    key  = {$urandom, $urandom};
    pt   = $urandom;
    ct   = encrypt(key, pt);
    key2 = {$urandom, $urandom};
    pt2  = $urandom;
    ct2  = encrypt(key2, pt2);
    exp_q.push_back(pt);
    accept_job(key, ct);
    bus.key_in   = key2;
    bus.ct_in    = ct2;
    bus.in_valid = 1'b1;
    check_rounds(key, ct);
    chk("done_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("overlap_idle", state_dbg, IDLE);
    chk("overlap_key_kept", core_key, key);
    exp_q.push_back(pt2);
    accept_job(key2, ct2);
    check_rounds(key2, ct2);
    drain(0);
`else
    // Prefetch: job B accepted during A's rounds, started right after A's handshake.
    key  = {$urandom, $urandom};
    pt   = $urandom;
    ct   = encrypt(key, pt);
    key2 = {$urandom, $urandom};
    pt2  = $urandom;
    ct2  = encrypt(key2, pt2);
    exp_q.push_back(pt);
    exp_q.push_back(pt2);
    accept_job(key, ct);
    repeat (10) step();
    chk("pf_ready_round", bus.in_ready, 1);
    bus.key_in   = key2;
    bus.ct_in    = ct2;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("pf_ready_full", bus.in_ready, 0);
    chk("pf_key_a_kept", core_key, key);
    wait_out_valid(ta);
    chk("pf_pt_a", bus.pt_out, exp_q.pop_front());
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pf_load_state", state_dbg, LOAD);
    chk("pf_load_strobe", core_load, 1);
    chk("pf_key_b", core_key, key2);
    chk("pf_text_b", core_text, ct2);
    chk("pf_ready_empty", bus.in_ready, 1);
    wait_out_valid(tb);
    chk("pf_spacing", tb - ta, 34);
    chk("pf_pt_b", bus.pt_out, exp_q.pop_front());
    drain(0);
`endif

    // Reset mid-job at round 15, then the known answer again.
    accept_job({$urandom, $urandom}, $urandom);
    repeat (16) step();
    chk("mid_count15", core_count, 15);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_count", core_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_load", core_load, 0);
    chk("mid_rst_pt", bus.pt_out, 0);
    chk("mid_rst_state", state_dbg, IDLE);
    #1;
    rst = 1'b0;
    step();
    exp_q.push_back(KAT_PT);
    accept_job(KAT_KEY, KAT_CT);
    check_rounds(KAT_KEY, KAT_CT);
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
